// File: rtl/buzzer_timer_pkg.sv
// buzzer_timer_pkg: state/tone encodings, widths and a counter-width helper
package buzzer_timer_pkg;
    localparam int SEC_W = 8;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_ALARM  = 3'd4
    } state_t;
    typedef enum logic [1:0] {
        TONE_F1 = 2'd0,
        TONE_F2 = 2'd1,
        TONE_F3 = 2'd2
    } tone_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave toggling every half_i cycles while enabled, held low otherwise
module tone_gen #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] half_i,
    output logic         wave_o
);
    logic [W-1:0] cnt_q;
    logic         wave_q;
    logic         hit;
    assign hit    = cnt_q == half_i - W'(1);
    assign wave_o = wave_q;
    // half-period counter; dropping enable clears both counter and output on the same edge
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= hit ? '0 : cnt_q + W'(1);
            wave_q <= wave_q ^ hit;
        end
    end
endmodule

// File: rtl/buzzer_timer_ctrl.sv
// buzzer_timer_ctrl: countdown timer FSM with 1 Hz prescaler driving the alarm buzzer
module buzzer_timer_ctrl
    import buzzer_timer_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DUR_SEC   = 30,
    parameter int ALARM_SEC = 5,
    parameter int HALF1     = 25_000,
    parameter int HALF2     = 12_500,
    parameter int HALF3     = 6_250
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             start_p,
    input  logic             stop_p,
    input  logic             load_p,
    input  logic             clear_p,
    input  logic [2:0]       freq_sel,
    output logic             buzzer,
    output logic             tick_1hz,
    output logic [SEC_W-1:0] secs_left,
    output logic [2:0]       state_o,
    output logic             done
);
    localparam int PW   = cnt_w(TICK_DIV);
    localparam int HMAX = HALF1 > HALF2 ? (HALF1 > HALF3 ? HALF1 : HALF3)
                                        : (HALF2 > HALF3 ? HALF2 : HALF3);
    localparam int HW   = cnt_w(HMAX + 1);

    state_t           state_q;
    tone_t            tone_q;
    logic [PW-1:0]    presc_q;
    logic [SEC_W-1:0] secs_q;
    logic [SEC_W-1:0] alarm_q;
    logic             tick_q;
    logic             done_q;
    logic [HW-1:0]    half;
    logic             wrap;
    logic             run_alarm;
    logic             do_stop;
    logic             do_start;
    logic             do_load;
    logic             tone_en;

    assign wrap      = presc_q == PW'(TICK_DIV - 1);
    assign run_alarm = state_q == ST_RUN || state_q == ST_ALARM;
    // Pulse priority is by presence: a higher pulse masks lower ones even when it is itself ignored
    assign do_stop   = stop_p && run_alarm;
    assign do_start  = start_p && !stop_p && (state_q == ST_LOADED || state_q == ST_PAUSE);
    assign do_load   = load_p && !stop_p && !start_p &&
                       (state_q == ST_IDLE || state_q == ST_LOADED || state_q == ST_PAUSE);
    // Drop the tone enable on the exit edge itself so the buzzer clears together with the state
    assign tone_en   = state_q == ST_ALARM && !clear_p && !stop_p && !(wrap && alarm_q <= SEC_W'(1));
    assign half      = tone_q == TONE_F3 ? HW'(HALF3) : tone_q == TONE_F2 ? HW'(HALF2) : HW'(HALF1);

    assign tick_1hz  = tick_q;
    assign done      = done_q;
    assign secs_left = secs_q;
    assign state_o   = state_q;

    // FSM, prescaler, countdown and alarm counters with registered pulse outputs
    always_ff @(posedge clk_50MHz) begin
        tick_q <= 1'b0;
        done_q <= 1'b0;
        if (reset) begin
            state_q <= ST_IDLE;
            tone_q  <= TONE_F1;
            presc_q <= '0;
            secs_q  <= '0;
            alarm_q <= '0;
        end else if (clear_p) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            secs_q  <= '0;
        end else if (state_q > ST_ALARM) begin
            state_q <= ST_IDLE;
        end else if (do_stop) begin
            state_q <= state_q == ST_RUN ? ST_PAUSE : ST_IDLE;
        end else if (do_start) begin
            state_q <= ST_RUN;
        end else if (do_load) begin
            state_q <= ST_LOADED;
            secs_q  <= SEC_W'(DUR_SEC);
            presc_q <= '0;
            tone_q  <= freq_sel[2] ? TONE_F3 : freq_sel[1] ? TONE_F2 : freq_sel[0] ? TONE_F1 : tone_q;
        end else if (run_alarm) begin
            presc_q <= wrap ? '0 : presc_q + PW'(1);
            tick_q  <= wrap;
            if (wrap && state_q == ST_RUN) begin
                secs_q <= secs_q > SEC_W'(1) ? secs_q - SEC_W'(1) : '0;
                if (secs_q <= SEC_W'(1)) begin
                    state_q <= ST_ALARM;
                    done_q  <= 1'b1;
                    alarm_q <= SEC_W'(ALARM_SEC);
                end
            end
            if (wrap && state_q == ST_ALARM) begin
                alarm_q <= alarm_q > SEC_W'(1) ? alarm_q - SEC_W'(1) : '0;
                if (alarm_q <= SEC_W'(1)) state_q <= ST_IDLE;
            end
        end
    end

    tone_gen #(.W(HW)) u_tone (
        .clk_i  (clk_50MHz),
        .rst_i  (reset),
        .en_i   (tone_en),
        .half_i (half),
        .wave_o (buzzer)
    );
endmodule

// File: tb/tb_buzzer_timer_ctrl.sv
// tb_buzzer_timer_ctrl: directed stimulus with a scoreboard monitor for events and buzzer periods
module tb_buzzer_timer_ctrl;
    localparam logic [2:0] IDLE = 3'd0, LOADED = 3'd1, RUN = 3'd2, PAUSE = 3'd3, ALARM = 3'd4;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b1;
    logic       start_p = 1'b0, stop_p = 1'b0, load_p = 1'b0, clear_p = 1'b0;
    logic [2:0] freq_sel = 3'b000;
    logic       buzzer, tick_1hz, done;
    logic [7:0] secs_left;
    logic [2:0] state_o;

    typedef struct {
        string      name;
        logic [7:0] secs;
        logic [2:0] st;
        logic       tick;
        logic       done;
        logic       buzz;
    } exp_t;

    exp_t q_evt[$];
    int   q_per[$];
    int   checks = 0, errors = 0, cyc = 0, ref_cyc = 0, per = 0;
    logic probe = 1'b0, buzz_prev = 1'b0;
    exp_t e;

    buzzer_timer_ctrl #(
        .TICK_DIV(10), .DUR_SEC(3), .ALARM_SEC(2), .HALF1(2), .HALF2(3), .HALF3(4)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .start_p   (start_p),
        .stop_p    (stop_p),
        .load_p    (load_p),
        .clear_p   (clear_p),
        .freq_sel  (freq_sel),
        .buzzer    (buzzer),
        .tick_1hz  (tick_1hz),
        .secs_left (secs_left),
        .state_o   (state_o),
        .done      (done)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Monitor: pops on any tick/done/probe and on every buzzer rising edge
    always @(negedge clk_50MHz) begin
        cyc = cyc + 1;
        if (done) ref_cyc = cyc;
        if (buzzer && !buzz_prev) begin
            checks = checks + 1;
            if (q_per.size() == 0) begin
                errors = errors + 1;
                $display("FAIL buzz_rise unexpected rise at cycle %0d", cyc);
            end else begin
                per = q_per.pop_front();
                if (cyc - ref_cyc != per) begin
                    errors = errors + 1;
                    $display("FAIL buzz_period got %0d cycles, want %0d", cyc - ref_cyc, per);
                end
            end
            ref_cyc = cyc;
        end
        buzz_prev = buzzer;
        if (tick_1hz || done || probe) begin
            checks = checks + 1;
            if (q_evt.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event cycle %0d secs=%0d st=%0d tick=%b done=%b",
                         cyc, secs_left, state_o, tick_1hz, done);
            end else begin
                e = q_evt.pop_front();
                if ({secs_left, state_o, tick_1hz, done, buzzer} !== {e.secs, e.st, e.tick, e.done, e.buzz}) begin
                    errors = errors + 1;
                    $display("FAIL %s got secs=%0d st=%0d tick=%b done=%b buzz=%b, want secs=%0d st=%0d tick=%b done=%b buzz=%b",
                             e.name, secs_left, state_o, tick_1hz, done, buzzer,
                             e.secs, e.st, e.tick, e.done, e.buzz);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic st, input logic sp, input logic ld, input logic cl);
        start_p = st;
        stop_p  = sp;
        load_p  = ld;
        clear_p = cl;
        step();
        start_p = 1'b0;
        stop_p  = 1'b0;
        load_p  = 1'b0;
        clear_p = 1'b0;
    endtask

    task automatic chk(input string n, input logic [7:0] s, input logic [2:0] st,
                       input logic t, input logic d, input logic b);
        exp_t x;
        x.name = n;
        x.secs = s;
        x.st   = st;
        x.tick = t;
        x.done = d;
        x.buzz = b;
        q_evt.push_back(x);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic countdown(input logic ld);
        wait_n(10);
        chk("tick_3to2", 8'd2, RUN, 1'b1, 1'b0, 1'b0);
        wait_n(4);
        if (ld) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        else step();
        wait_n(4);
        chk("tick_2to1", 8'd1, RUN, 1'b1, 1'b0, 1'b0);
        wait_n(9);
        chk("expire", 8'd0, ALARM, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_n(3);
        reset = 1'b0;
        chk("reset", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // full countdown with freq1, alarm for two seconds
        freq_sel = 3'b001;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_load", 8'd3, LOADED, 1'b0, 1'b0, 1'b0);
        q_per.push_back(2);
        repeat (4) q_per.push_back(4);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        countdown(1'b0);
        wait_n(9);
        chk("t1_alarm_tick", 8'd0, ALARM, 1'b1, 1'b0, 1'b1);
        wait_n(9);
        chk("t1_alarm_end", 8'd0, IDLE, 1'b1, 1'b0, 1'b0);
        chk("t1_idle", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // pause after 15 running cycles, hold, resume with 5 cycles left in the second
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_n(10);
        chk("t2_tick", 8'd2, RUN, 1'b1, 1'b0, 1'b0);
        wait_n(4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_pause", 8'd2, PAUSE, 1'b0, 1'b0, 1'b0);
        wait_n(49);
        chk("t2_hold", 8'd2, PAUSE, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_n(4);
        chk("t2_pre_tick", 8'd2, RUN, 1'b0, 1'b0, 1'b0);
        chk("t2_resume_tick", 8'd1, RUN, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_clear", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // freq3 wins over freq2: period 8
        freq_sel = 3'b110;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        q_per.push_back(4);
        q_per.push_back(8);
        countdown(1'b0);
        wait_n(9);
        chk("t3_alarm_tick", 8'd0, ALARM, 1'b1, 1'b0, 1'b0);
        wait_n(9);
        chk("t3_alarm_end", 8'd0, IDLE, 1'b1, 1'b0, 1'b0);
        // same-cycle pulse priority in PAUSE
        freq_sel = 3'b000;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_n(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_pause", 8'd3, PAUSE, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_stop_start", 8'd3, PAUSE, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_clear_load", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // freq_sel=0 keeps freq3, load ignored in RUN, stop silences ALARM
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        freq_sel = 3'b001;
        q_per.push_back(4);
        countdown(1'b1);
        wait_n(4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_alarm_stop", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // reset with clear mid-ALARM while the buzzer is high
        freq_sel = 3'b100;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        q_per.push_back(4);
        countdown(1'b0);
        wait_n(4);
        reset   = 1'b1;
        clear_p = 1'b1;
        step();
        reset   = 1'b0;
        clear_p = 1'b0;
        chk("t6_reset", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        // reset restored freq1, so freq_sel=0 plays freq1
        freq_sel = 3'b000;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        q_per.push_back(2);
        countdown(1'b0);
        wait_n(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t7_stop", 8'd0, IDLE, 1'b0, 1'b0, 1'b0);
        wait_n(3);
        checks = checks + 1;
        if (q_evt.size() != 0 || q_per.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover got %0d events %0d periods pending, want 0 0", q_evt.size(), q_per.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
